// File: rtl/calc_pkg.sv
// Shared state encoding and operation codes for the calculator control path.
package calc_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_OP = 3'd1,
        WAIT_B  = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

endpackage

// File: rtl/calc_input_fsm_rise_detect.sv
// Purpose: registered rising-edge detector for a level input already synchronous to clk.
// Latency: the rise output is combinational from d against the previous-cycle register.
// Backpressure: none; the output pulses once per low-to-high transition.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) d_q <= RST_VAL;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/calc_input_fsm.sv
// Purpose: sequences A / op / B entry, drives the arithmetic unit and registers its result.
// Latency: result registers at the edge ending the single EXEC cycle.
// Backpressure: none; one action per ENTER press, and clear overrides everything.
module calc_input_fsm
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [1:0]           op_in,
    input  logic                 enter,
    input  logic                 clear,
    input  logic [2*WIDTH-1:0]   au_result,
    output logic [1:0]           au_signal,
    output logic [WIDTH-1:0]     au_a,
    output logic [WIDTH-1:0]     au_b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_valid,
    output logic                 overflow,
    output logic [2:0]           state
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [1:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 overflow_q, overflow_d;
    logic                 enter_rise;

    // Reset value 1 keeps an ENTER held through reset from firing on release.
    rise_detect #(.RST_VAL(1'b1)) u_enter_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (enter),
        .rise  (enter_rise)
    );

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        au_signal  = OP_PASS;

        case (state_q)
            WAIT_A: if (enter_rise) begin
                a_d     = data_in;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (enter_rise) begin
                op_d    = op_in;
                state_d = (op_in == OP_PASS) ? EXEC : WAIT_B;
            end
            WAIT_B: if (enter_rise) begin
                b_d     = data_in;
                state_d = EXEC;
            end
            EXEC: begin
                au_signal  = op_q;
                result_d   = au_result;
                overflow_d = |au_result[2*WIDTH-1:WIDTH];
                state_d    = SHOW;
            end
            SHOW: if (enter_rise) begin
                // Chaining keeps only the low half, even when the result overflowed.
                a_d     = result_q[WIDTH-1:0];
                b_d     = '0;
                state_d = WAIT_OP;
            end
            default: state_d = WAIT_A;
        endcase

        if (clear) begin
            state_d    = WAIT_A;
            a_d        = '0;
            b_d        = '0;
            op_d       = OP_PASS;
            result_d   = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= WAIT_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_PASS;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign au_a         = a_q;
    assign au_b         = b_q;
    assign result       = result_q;
    assign overflow     = overflow_q;
    assign result_valid = (state_q == SHOW);
    assign state        = state_q;

endmodule

// File: tb/tb_calc_input_fsm.sv
// Bench for calc_input_fsm with a behavioural arithmetic unit beside it.
module tb_calc_input_fsm;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   data_in;
    logic [1:0]     op_in;
    logic           enter;
    logic           clear;
    logic [2*W-1:0] au_result;
    logic [1:0]     au_signal;
    logic [W-1:0]   au_a;
    logic [W-1:0]   au_b;
    logic [2*W-1:0] result;
    logic           result_valid;
    logic           overflow;
    logic [2:0]     state;

    int checks   = 0;
    int failures = 0;

    calc_input_fsm #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .op_in        (op_in),
        .enter        (enter),
        .clear        (clear),
        .au_result    (au_result),
        .au_signal    (au_signal),
        .au_a         (au_a),
        .au_b         (au_b),
        .result       (result),
        .result_valid (result_valid),
        .overflow     (overflow),
        .state        (state)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (au_signal)
            2'b01:   au_result = {8'h00, au_a} + {8'h00, au_b};
            2'b10:   au_result = {8'h00, au_a} - {8'h00, au_b};
            2'b11:   au_result = au_a * au_b;
            default: au_result = {8'h00, au_a};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One idle low cycle, then a one-cycle ENTER pulse; returns just after the sampling edge.
    task automatic press(input logic [W-1:0] d, input logic [1:0] op);
        step();
        data_in = d;
        op_in   = op;
        enter   = 1'b1;
        step();
        enter   = 1'b0;
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [1:0]     op;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_res;
        logic           exp_ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{a: 8'd25,  op: 2'b01, b: 8'd17,  exp_res: 16'd42,   exp_ovf: 1'b0};
        vecs[1] = '{a: 8'd3,   op: 2'b10, b: 8'd5,   exp_res: 16'hFFFE, exp_ovf: 1'b1};
        vecs[2] = '{a: 8'd200, op: 2'b11, b: 8'd200, exp_res: 16'h9C40, exp_ovf: 1'b1};
        vecs[3] = '{a: 8'd7,   op: 2'b00, b: 8'd0,   exp_res: 16'd7,    exp_ovf: 1'b0};
        vecs[4] = '{a: 8'd255, op: 2'b01, b: 8'd255, exp_res: 16'h01FE, exp_ovf: 1'b1};
        vecs[5] = '{a: 8'd100, op: 2'b10, b: 8'd40,  exp_res: 16'd60,   exp_ovf: 1'b0};
        vecs[6] = '{a: 8'd15,  op: 2'b11, b: 8'd17,  exp_res: 16'd255,  exp_ovf: 1'b0};
        vecs[7] = '{a: 8'd16,  op: 2'b11, b: 8'd16,  exp_res: 16'h0100, exp_ovf: 1'b1};

        rst_n = 1'b0; data_in = '0; op_in = '0; enter = 1'b0; clear = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_au_a", 32'(au_a), 32'd0);

        foreach (vecs[i]) begin
            clear_pulse();
            press(vecs[i].a, 2'b00);
            check($sformatf("v%0d_wait_op", i), 32'(state), 32'd1);
            press(8'h00, vecs[i].op);
            if (vecs[i].op != 2'b00) begin
                check($sformatf("v%0d_wait_b", i), 32'(state), 32'd2);
                press(vecs[i].b, 2'b00);
            end
            check($sformatf("v%0d_exec", i), 32'(state), 32'd3);
            check($sformatf("v%0d_au_signal", i), 32'(au_signal), 32'(vecs[i].op));
            check($sformatf("v%0d_valid_exec", i), 32'(result_valid), 32'd0);
            step();
            check($sformatf("v%0d_show", i), 32'(state), 32'd4);
            check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].exp_res));
            check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("v%0d_valid", i), 32'(result_valid), 32'd1);
            check($sformatf("v%0d_au_signal_show", i), 32'(au_signal), 32'd0);
        end

        // Chain the overflowed 200*200 result: low byte 0x40, then +1.
        clear_pulse();
        press(8'd200, 2'b00);
        press(8'h00, 2'b11);
        press(8'd200, 2'b00);
        step();
        check("chain_pre_result", 32'(result), 32'h9C40);
        press(8'hAA, 2'b00);
        check("chain_state", 32'(state), 32'd1);
        check("chain_a", 32'(au_a), 32'h40);
        check("chain_b", 32'(au_b), 32'h00);
        press(8'h00, 2'b01);
        press(8'd1, 2'b00);
        step();
        check("chain_result", 32'(result), 32'd65);
        check("chain_ovf", 32'(overflow), 32'd0);

        // Reset during EXEC while an old result is still registered.
        press(8'h00, 2'b00);
        press(8'h00, 2'b01);
        press(8'd3, 2'b00);
        check("rst_exec_pre", 32'(state), 32'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_exec_state", 32'(state), 32'd0);
        check("rst_exec_result", 32'(result), 32'd0);
        check("rst_exec_valid", 32'(result_valid), 32'd0);

        // ENTER held for 10 cycles: exactly one capture, later data ignored.
        step();
        data_in = 8'h11;
        enter   = 1'b1;
        step();
        data_in = 8'h22;
        op_in   = 2'b01;
        for (int k = 0; k < 9; k++) step();
        check("hold_state", 32'(state), 32'd1);
        check("hold_a", 32'(au_a), 32'h11);
        enter = 1'b0;

        // ENTER held through reset release must not fire.
        clear_pulse();
        enter   = 1'b1;
        data_in = 8'h33;
        rst_n   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        check("rst_hold_state", 32'(state), 32'd0);
        check("rst_hold_a", 32'(au_a), 32'd0);
        enter = 1'b0;

        // clear in WAIT_B with A=9.
        press(8'd9, 2'b00);
        press(8'h00, 2'b01);
        check("clr_pre_state", 32'(state), 32'd2);
        check("clr_pre_a", 32'(au_a), 32'd9);
        clear_pulse();
        check("clr_state", 32'(state), 32'd0);
        check("clr_a", 32'(au_a), 32'd0);

        // clear beats a simultaneous ENTER, and the press is consumed during clear.
        step();
        data_in = 8'd5;
        enter   = 1'b1;
        clear   = 1'b1;
        step();
        clear = 1'b0;
        check("clr_prio_state", 32'(state), 32'd0);
        step();
        check("clr_prio_after", 32'(state), 32'd0);
        check("clr_prio_a", 32'(au_a), 32'd0);
        enter = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_input_fsm.md
Name: calc_input_fsm

Overview:
- Upstream control stage for the calculator's arithmetic unit.
- Sequences operand/operation entry from switches plus an ENTER button: operand A, then operation, then operand B.
- Drives the arithmetic unit's op-select and operand inputs, captures its 16-bit combinational result into a registered result with an overflow flag, and supports chaining the result into the next calculation.

Parameters:
- WIDTH, 8, operand width in bits; result width is 2*WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- data_in  input  WIDTH  operand switches
- op_in  input  2  operation switches: 00 pass-A, 01 add, 10 sub, 11 mul
- enter  input  1  ENTER button, level, already debounced
- clear  input  1  synchronous clear, level, active-high
- au_result  input  2*WIDTH  combinational result from arithmetic unit
- au_signal  output  2  op select to arithmetic unit
- au_a  output  WIDTH  operand A to arithmetic unit
- au_b  output  WIDTH  operand B to arithmetic unit
- result  output  2*WIDTH  registered result
- result_valid  output  1  high while in SHOW
- overflow  output  1  result exceeds WIDTH bits (or subtraction borrowed)
- state  output  3  current state encoding, for display/debug

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=WAIT_A; A, B, OP, result, overflow all 0.
  - enter_q=1, so an ENTER held through reset does not fire.
- ENTER edge detection:
  - enter_rise = enter & ~enter_q; enter_q <= enter every cycle.
  - One action per press; holding ENTER high never repeats.
- State encoding: WAIT_A=0, WAIT_OP=1, WAIT_B=2, EXEC=3, SHOW=4. Codes 5-7 are illegal and go to WAIT_A on the next edge.
- State transitions:
  - WAIT_A: on enter_rise, A<=data_in, go to WAIT_OP.
  - WAIT_OP: on enter_rise, OP<=op_in. If op_in==00, go to EXEC (B unused, B unchanged); else go to WAIT_B.
  - WAIT_B: on enter_rise, B<=data_in, go to EXEC.
  - EXEC: exactly one cycle, no ENTER needed.
    - au_signal=OP.
    - result<=au_result; overflow<=|au_result[2*WIDTH-1:WIDTH].
    - Go to SHOW.
  - SHOW: result_valid=1; result and overflow hold. On enter_rise (chain): A<=result[WIDTH-1:0] (truncated even if overflow=1), B<=0, go to WAIT_OP.
- Datapath outputs:
  - au_a=A and au_b=B at all times (registered values).
  - au_signal=OP only in EXEC, else 2'b00.
- Clear: clear=1 at an edge forces reset values for state, A, B, OP, result and overflow, from any state. clear has priority over enter_rise. enter_q still updates normally during clear.
- Latency: the result is registered at the edge that ends EXEC. result_valid rises one cycle after the final ENTER edge is sampled.
- Width rules:
  - Add: up to 9 bits.
  - Sub: wraps modulo 2^(2*WIDTH) when B>A, e.g. 3-5=16'hFFFE, overflow=1.
  - Mul: up to 16 bits.
- Inputs are not synchronised here; enter, clear, data_in and op_in arrive already synchronous to clk.

Decomposition:
- Package calc_pkg holds:
  - state localparams (WAIT_A..SHOW, 3-bit);
  - op codes OP_PASS=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_MUL=2'b11.
- Sub-module rise_detect: 1-bit registered rising-edge detector with a reset-value parameter (here 1).
- The arithmetic unit is instantiated beside this block at top level, not inside it.

Test Plan:
- 25, ENTER, op 01, ENTER, 17, ENTER -> EXEC for one cycle, then SHOW; result=16'd42, overflow=0, result_valid=1.
- 3, ENTER, op 10, ENTER, 5, ENTER -> result=16'hFFFE, overflow=1.
- 200 * 200 -> result=16'h9C40 (40000), overflow=1. Then ENTER, op 01, ENTER, 1, ENTER -> chained A=8'h40, result=16'd65.
- 7, ENTER, op 00, ENTER -> goes straight to EXEC (WAIT_B skipped); result=16'd7.
- ENTER held high for 10 cycles in WAIT_A -> exactly one capture, state=WAIT_OP. ENTER held high through reset release -> no capture, state stays WAIT_A.
- clear in WAIT_B with A=9 -> next cycle state=WAIT_A, au_a=0. rst_n=0 during EXEC -> state=WAIT_A, result=0, result_valid=0.
